// File: rtl/prco_fetch_if.sv
// prco_fetch_if: instruction-memory read port (level req, single-cycle ack).
// The master is the fetch stage and the slave is the instruction memory.
interface prco_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              q_mem_req;
  logic [ADDR_W-1:0] q_mem_addr;
  logic              i_mem_ack;
  logic [15:0]       i_mem_data;

  modport master (
    output q_mem_req,
    output q_mem_addr,
    input  i_mem_ack,
    input  i_mem_data
  );

  modport slave (
    input  q_mem_req,
    input  q_mem_addr,
    output i_mem_ack,
    output i_mem_data
  );
endinterface

// File: rtl/prco_fetch.sv
// prco_fetch: PRCO instruction fetch stage (program counter, memory read, decoder handoff).
// Define PRCO_FETCH_TIMEOUT_EN to add a 16-cycle read timeout with a sticky q_err flag.
module prco_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_fetch,
  input  logic              i_jmp,
  input  logic [ADDR_W-1:0] i_jmp_addr,
  prco_fetch_if.master      mem,
  output logic [15:0]       q_instr,
  output logic              q_ce,
  output logic [ADDR_W-1:0] q_pc,
  output logic              q_busy,
  output logic              q_err
);

  // state   | meaning
  // S_START | out of reset; first fetch starts as soon as i_en is high
  // S_WAIT  | read outstanding, q_mem_req held high
  // S_HOLD  | idle until i_fetch, i_jmp or a remembered request
  typedef enum logic [1:0] {S_START, S_WAIT, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic              req_r, req_nxt;
  logic [15:0]       instr_nxt;
  logic [ADDR_W-1:0] qpc_nxt;
  logic              ce_nxt;
  logic              pend, pend_nxt;
  logic              kill, kill_nxt;
  logic [ADDR_W-1:0] tgt, tgt_nxt;
  logic              issue;

`ifdef PRCO_FETCH_TIMEOUT_EN
  logic [3:0] cnt, cnt_nxt;
  logic       err_r, err_nxt;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_r;
    req_nxt   = req_r;
    instr_nxt = q_instr;
    qpc_nxt   = q_pc;
    ce_nxt    = 1'b0;
    pend_nxt  = pend;
    kill_nxt  = kill;
    tgt_nxt   = tgt;
    issue     = 1'b0;
`ifdef PRCO_FETCH_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = err_r;
`endif
    unique case (state)
      S_START: begin
        if (i_jmp) pc_nxt = i_jmp_addr;
        if (i_en) issue = 1'b1;
      end
      S_HOLD: begin
        if (i_jmp) pc_nxt = i_jmp_addr;
        if (i_en && (i_jmp || i_fetch || pend)) issue = 1'b1;
        else if (i_jmp || i_fetch) pend_nxt = 1'b1;
      end
      S_WAIT: begin
        if (mem.i_mem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_HOLD;
          if (kill || i_jmp) begin
            // redirected read: discard the word and refetch from the target
            pc_nxt   = i_jmp ? i_jmp_addr : tgt;
            kill_nxt = 1'b0;
            pend_nxt = 1'b1;
          end else begin
            instr_nxt = mem.i_mem_data;
            qpc_nxt   = pc;
            pc_nxt    = pc + 1'b1;
            ce_nxt    = 1'b1;
          end
        end else begin
          if (i_jmp) begin
            kill_nxt = 1'b1;
            tgt_nxt  = i_jmp_addr;
          end
`ifdef PRCO_FETCH_TIMEOUT_EN
          if (cnt == 4'hF) begin
            err_nxt   = 1'b1;
            req_nxt   = 1'b0;
            state_nxt = S_HOLD;
            pend_nxt  = 1'b1;
            if (kill_nxt) begin
              pc_nxt   = tgt_nxt;
              kill_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
`endif
        end
      end
      default: state_nxt = S_START;
    endcase
    if (issue) begin
      state_nxt = S_WAIT;
      req_nxt   = 1'b1;
      addr_nxt  = pc_nxt;
      pend_nxt  = 1'b0;
      kill_nxt  = 1'b0;
`ifdef PRCO_FETCH_TIMEOUT_EN
      cnt_nxt   = 4'd0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_START;
      pc      <= RESET_PC;
      addr_r  <= RESET_PC;
      req_r   <= 1'b0;
      q_instr <= 16'h0000;
      q_pc    <= RESET_PC;
      q_ce    <= 1'b0;
      pend    <= 1'b0;
      kill    <= 1'b0;
      tgt     <= RESET_PC;
`ifdef PRCO_FETCH_TIMEOUT_EN
      cnt     <= 4'd0;
      err_r   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      addr_r  <= addr_nxt;
      req_r   <= req_nxt;
      q_instr <= instr_nxt;
      q_pc    <= qpc_nxt;
      q_ce    <= ce_nxt;
      pend    <= pend_nxt;
      kill    <= kill_nxt;
      tgt     <= tgt_nxt;
`ifdef PRCO_FETCH_TIMEOUT_EN
      cnt     <= cnt_nxt;
      err_r   <= err_nxt;
`endif
    end
  end

  assign mem.q_mem_req  = req_r;
  assign mem.q_mem_addr = addr_r;
  assign q_busy         = req_r;

`ifdef PRCO_FETCH_TIMEOUT_EN
  assign q_err = err_r;
`else
  assign q_err = 1'b0;
`endif

endmodule

// File: tb/tb_prco_fetch.sv
// tb_prco_fetch: directed bench for prco_fetch with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_prco_fetch;
  localparam int         AW  = 8;
  localparam logic [7:0] RPC = 8'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        fetch = 1'b0;
  logic        jmp = 1'b0;
  logic [7:0]  jaddr = 8'h00;
  logic [15:0] instr;
  logic        ce;
  logic [7:0]  qpc;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  prco_fetch_if #(.ADDR_W(AW)) mif ();

  prco_fetch #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_fetch    (fetch),
    .i_jmp      (jmp),
    .i_jmp_addr (jaddr),
    .mem        (mif),
    .q_instr    (instr),
    .q_ce       (ce),
    .q_pc       (qpc),
    .q_busy     (busy),
    .q_err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // memory: acks in the delay-th cycle of a request; delay 0 never acks
  logic [15:0] mem [256];
  int delay = 1;
  int rcnt = 0;
  always @(negedge clk) begin
    if (mif.q_mem_req === 1'b1 && delay != 0) begin
      rcnt++;
      mif.i_mem_ack = (rcnt == delay);
    end else begin
      rcnt = 0;
      mif.i_mem_ack = 1'b0;
    end
    mif.i_mem_data = mem[mif.q_mem_addr];
  end

  // reference model: "want" means a fetch is owed; the first one is owed from reset
  logic        m_req, m_ce, m_err, m_want, m_doom, prev_ce;
  logic [7:0]  m_addr, m_qpc, m_pc, m_tgt;
  logic [15:0] m_instr;
  logic        s_rst, s_en, s_fetch, s_jmp, s_ack, want_now;
  logic [7:0]  s_jaddr;
  logic [15:0] s_data;
`ifdef PRCO_FETCH_TIMEOUT_EN
  int          m_waited;
`endif

  always @(posedge clk) begin
    s_rst = rst; s_en = en; s_fetch = fetch; s_jmp = jmp; s_jaddr = jaddr;
    s_ack = mif.i_mem_ack; s_data = mif.i_mem_data;
    if (s_rst) begin
      m_req = 1'b0; m_addr = RPC; m_instr = 16'h0000; m_ce = 1'b0; m_qpc = RPC;
      m_err = 1'b0; m_pc = RPC; m_want = 1'b1; m_doom = 1'b0; m_tgt = RPC;
      prev_ce = 1'b0;
    end else begin
      m_ce = 1'b0;
      if (m_req) begin
        if (s_ack === 1'b1) begin
          m_req = 1'b0;
          if (m_doom || s_jmp) begin
            m_pc = s_jmp ? s_jaddr : m_tgt;
            m_doom = 1'b0;
            m_want = 1'b1;
          end else begin
            m_instr = s_data;
            m_qpc = m_pc;
            m_pc = m_pc + 8'd1;
            m_ce = 1'b1;
          end
        end else begin
          if (s_jmp) begin
            m_doom = 1'b1;
            m_tgt = s_jaddr;
          end
`ifdef PRCO_FETCH_TIMEOUT_EN
          m_waited++;
          if (m_waited == 16) begin
            m_err = 1'b1;
            m_req = 1'b0;
            m_want = 1'b1;
            if (m_doom) begin
              m_pc = m_tgt;
              m_doom = 1'b0;
            end
          end
`endif
        end
      end else begin
        want_now = m_want || s_fetch || s_jmp;
        if (s_jmp) m_pc = s_jaddr;
        if (want_now && s_en) begin
          m_req = 1'b1;
          m_addr = m_pc;
          m_want = 1'b0;
          m_doom = 1'b0;
`ifdef PRCO_FETCH_TIMEOUT_EN
          m_waited = 0;
`endif
        end else begin
          m_want = want_now;
        end
      end
    end
    #1;
    chk("req", mif.q_mem_req, m_req);
    chk("busy", busy, m_req);
    chk("addr", mif.q_mem_addr, m_addr);
    chk("ce", ce, m_ce);
    chk("instr", instr, m_instr);
    chk("pc", qpc, m_qpc);
    chk("err", err, m_err);
    chk("ce_gap", ce & prev_ce, 1'b0);
    prev_ce = ce;
  end

  task automatic wait_ce(input int max, output int edges, output int busy_n);
    edges = 0;
    busy_n = 0;
    do begin
      @(posedge clk); #1;
      fetch = 1'b0; jmp = 1'b0;
      edges++;
      if (busy) busy_n++;
    end while (!ce && edges < max);
    chk("ce_arrives", ce, 1'b1);
  endtask

  task automatic count_ce(input int n, output int nce, output logic [7:0] pc0);
    nce = 0;
    pc0 = 8'h00;
    repeat (n) begin
      @(posedge clk); #1;
      fetch = 1'b0; jmp = 1'b0;
      if (ce) begin
        if (nce == 0) pc0 = qpc;
        nce++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, b, nce, nreq;
    logic [7:0] pc0, a0;
    logic prev_req;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + i[15:0];
    mem[8] = 16'h4A12;

    // reset, then zero-wait first fetch from RESET_PC
    repeat (2) @(negedge clk);
    chk("rst_req", mif.q_mem_req, 1'b0);
    chk("rst_pc", qpc, RPC);
    chk("rst_instr", instr, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_addr", mif.q_mem_addr, 8'd8);
    chk("first_req", mif.q_mem_req, 1'b1);
    wait_ce(10, e, b);
    chk("first_instr", instr, 16'h4A12);
    chk("first_pc", qpc, 8'd8);
    repeat (3) begin
      @(negedge clk);
      chk("hold_noreq", mif.q_mem_req, 1'b0);
    end

    // two fetches with a 3-cycle ack delay
    delay = 3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); fetch = 1'b1;
      wait_ce(10, e, b);
      chk("fetch_edges", e, 4);
      chk("fetch_busy", b, 3);
      chk("fetch_pc", qpc, 8'd9 + k[7:0]);
      chk("fetch_instr", instr, 16'h1009 + k[15:0]);
    end

    // wrap from 8'hFF to 8'h00
    delay = 1;
    @(negedge clk); jmp = 1'b1; jaddr = 8'hFF;
    @(posedge clk); #1; jmp = 1'b0;
    chk("wrap_addr_ff", mif.q_mem_addr, 8'hFF);
    wait_ce(10, e, b);
    chk("wrap_pc_ff", qpc, 8'hFF);
    @(negedge clk); fetch = 1'b1;
    @(posedge clk); #1; fetch = 1'b0;
    chk("wrap_addr_00", mif.q_mem_addr, 8'h00);
    wait_ce(10, e, b);
    chk("wrap_pc_00", qpc, 8'h00);
    chk("wrap_instr_00", instr, 16'h1000);

    // redirect to 8'h20 while the read of address 5 is outstanding
    delay = 3;
    @(negedge clk); jmp = 1'b1; jaddr = 8'h05;
    @(negedge clk); jaddr = 8'h20;
    count_ce(14, nce, pc0);
    chk("kill_ce_count", nce, 1);
    chk("kill_first_pc", pc0, 8'h20);
    chk("kill_instr", instr, 16'h1020);

    // jump and fetch in the same idle cycle: one request, to the target
    delay = 2;
    @(negedge clk); jmp = 1'b1; fetch = 1'b1; jaddr = 8'h40;
    @(negedge clk); jmp = 1'b0; fetch = 1'b0;
    nreq = 0; a0 = 8'h00; prev_req = 1'b0;
    repeat (8) begin
      if (mif.q_mem_req && !prev_req) begin
        nreq++;
        a0 = mif.q_mem_addr;
      end
      prev_req = mif.q_mem_req;
      @(negedge clk);
    end
    chk("jf_req_count", nreq, 1);
    chk("jf_addr", a0, 8'h40);
    chk("jf_pc", qpc, 8'h40);

    // jump on the ack cycle itself drops the word at 8'h41
    delay = 2;
    @(negedge clk); fetch = 1'b1;
    @(negedge clk); fetch = 1'b0;
    @(negedge clk); jmp = 1'b1; jaddr = 8'h30;
    count_ce(10, nce, pc0);
    chk("ackjmp_ce_count", nce, 1);
    chk("ackjmp_pc", pc0, 8'h30);

    // fetch with i_en low is remembered until i_en rises
    delay = 1;
    @(negedge clk); en = 1'b0; fetch = 1'b1;
    @(negedge clk); fetch = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("en_block", mif.q_mem_req, 1'b0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    chk("en_release_req", mif.q_mem_req, 1'b1);
    chk("en_release_addr", mif.q_mem_addr, 8'h31);
    wait_ce(10, e, b);
    chk("en_release_pc", qpc, 8'h31);

    // reset in the middle of a read, then a read that is never acked
    delay = 0;
    @(negedge clk); fetch = 1'b1;
    @(negedge clk); fetch = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", mif.q_mem_req, 1'b0);
    chk("midrst_pc", qpc, RPC);
    rst = 1'b0;
    repeat (20) @(negedge clk);
`ifdef PRCO_FETCH_TIMEOUT_EN
    chk("tmo_err", err, 1'b1);
`else
    chk("tmo_err", err, 1'b0);
`endif
    chk("tmo_req", mif.q_mem_req, 1'b1);
    chk("tmo_addr", mif.q_mem_addr, RPC);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prco_fetch.md
# prco_fetch

Instruction fetch stage of the PRCO core, sitting directly upstream of the decoder. Holds the program counter, issues one 16-bit instruction read per fetch request over a req/ack memory port, and presents each returned word to the decoder with a one-cycle `q_ce` pulse. It then idles until the pipeline asks for the next instruction via `i_fetch`, which is the decoder's `q_fetch` OR'd with the writeback-done strobe. It also accepts a redirect (`i_jmp`) from the execute stage.

## Interface
Parameters:
- `ADDR_W`, 8, program counter and instruction memory address width.
- `RESET_PC`, 0, first instruction address after reset.

Ports:
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst`  in  1  reset. Synchronous and active-high.
- `i_en`  in  1  stage enable; low blocks starting a new fetch.
- `i_fetch`  in  1  request for the next instruction, single-cycle strobe.
- `i_jmp`  in  1  redirect strobe.
- `i_jmp_addr`  in  ADDR_W  redirect target.
- `q_mem_req`  out  1  memory read request, level.
- `q_mem_addr`  out  ADDR_W  memory read address.
- `i_mem_ack`  in  1  read data valid this cycle.
- `i_mem_data`  in  16  read data.
- `q_instr`  out  16  instruction to the decoder (`i_instr`).
- `q_ce`  out  1  one-cycle valid pulse to the decoder (`i_ce`).
- `q_pc`  out  ADDR_W  address of the word in `q_instr`.
- `q_busy`  out  1  high while a memory read is outstanding.
- `q_err`  out  1  sticky fetch-timeout flag. Constant 0 unless `PRCO_FETCH_TIMEOUT_EN` is defined.

## Operation
- Internal `pc` holds the next fetch address. It increments by 1 on each accepted word and wraps from all-ones to 0.
- FSM states:
  - S_START (reset state): on `i_en` go to S_WAIT, asserting `q_mem_req` with `q_mem_addr = pc`.
  - S_WAIT: `q_mem_req` and `q_busy` are held high.
    - On `i_mem_ack`: `q_instr <= i_mem_data`, `q_pc <= pc`, `pc <= pc+1`, `q_ce <= 1`, `q_mem_req <= 0`, go to S_HOLD.
  - S_HOLD: wait for the next request.
    - On `i_fetch && i_en`: go to S_WAIT with `q_mem_addr = pc`.
    - With `i_en` low, `i_fetch` is remembered in a pending bit and honoured when `i_en` rises.
- Redirects:
  - `i_jmp` in S_HOLD or S_START: `pc <= i_jmp_addr`, then fetch immediately from the target. No `i_fetch` is needed, and `i_en` is still required.
  - `i_jmp` in S_WAIT: record the target and a kill bit. On ack, drop the data (no `q_ce`, `q_instr` unchanged), load `pc` from the target, and re-issue the request the following cycle.
  - `i_jmp` on the ack cycle itself: same as above, so the word is dropped.
- Simultaneous `i_jmp` and `i_fetch`: the jump target wins, and only one fetch is issued.
- `i_fetch` in S_WAIT is ignored, because the decoder never requests while busy.
- `i_mem_ack` while `q_mem_req` is low is ignored.
- `i_en` low never aborts an outstanding read.
- `q_ce` is never high in two consecutive cycles.

## Timing
- Reset values: `q_mem_req`=0, `q_mem_addr`=RESET_PC, `q_instr`=16'h0000, `q_ce`=0, `q_pc`=RESET_PC, `q_busy`=0, `q_err`=0. Internally, `pc`=RESET_PC, pending and kill bits are 0, state is S_START.
- Reset mid-read: `q_mem_req` drops on the next edge and the transaction is abandoned. Memory must not ack a request that has been withdrawn.
- `i_fetch` sampled at edge N: `q_mem_req` is high after N.
- Ack sampled at edge N+k (k≥1): `q_ce` is high for the cycle after N+k and `q_mem_req` is low after N+k.
- Minimum `i_fetch`→`q_ce` latency is 2 edges (ack returned in the first request cycle).
- Redirect during S_WAIT costs one dropped word plus a fresh request latency.

## Configuration
- `PRCO_FETCH_TIMEOUT_EN` defined:
  - A 4-bit counter clears on entering S_WAIT and counts each S_WAIT cycle without ack.
  - On the 16th such cycle: set `q_err` (sticky until `i_rst`), drop `q_mem_req` for one cycle, then re-issue the same address.
- Not defined: S_WAIT waits indefinitely, there is no counter, and `q_err` is tied to 0.

## Test plan
- Reset with RESET_PC=8, zero-wait memory returning 16'h4A12 at address 8, `i_en`=1 → `q_mem_addr`=8, `q_ce` pulses once with `q_instr`=16'h4A12 and `q_pc`=8, then S_HOLD with no further req.
- `i_fetch` pulses at words 8, 9 with 3-cycle ack delay → `q_ce` 4 edges after each `i_fetch`, `q_pc`=9 then 10, `q_busy` high for exactly 3 cycles each.
- ADDR_W=8, pc=8'hFF, `i_fetch` → read at 8'hFF, then next read at 8'h00.
- `i_jmp` with target 8'h20 during S_WAIT at address 5 → ack for 5 produces no `q_ce`, next `q_mem_addr`=8'h20, `q_pc`=8'h20 on the following `q_ce`.
- `i_jmp` and `i_fetch` in the same S_HOLD cycle, target 8'h40 → exactly one request, to 8'h40.
- With `PRCO_FETCH_TIMEOUT_EN`, memory never acks → after 16 wait cycles `q_err`=1, req low for 1 cycle, then req high at the same address. Without the macro, `q_err` stays 0 and req stays high.
